timer_cmp_bank: RTL and testbench

Multi-channel compare and interrupt bank for the timer subsystem. It generalises the single 64-bit compare/interrupt pair into NUM_CH independent channels, each supporting one-shot or periodic (auto-reload) operation, with per-channel status, enable and a combined interrupt. It sits beside the timer register set on the same APB-derived wr_en/rd_en bus. It consumes the shared 64-bit counter value and drives the interrupt line.

---
 rtl/timer_cmp_pkg.sv | 39 +++
 rtl/timer_cmp_ch.sv | 72 +++++++
 rtl/timer_cmp_bank.sv | 127 ++++++++++++
 tb/tb_timer_cmp_bank.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_cmp_pkg.sv
// Shared constants and types for the multi-channel timer compare bank:
// register map, CTRL bit positions and the per-channel state encoding.
package timer_cmp_pkg;

    localparam int TIMER_CNT_W = 64;
    localparam int MAX_CH      = 8;

    localparam logic [11:0] ADDR_ISR  = 12'h0F0;
    localparam logic [11:0] ADDR_IPR  = 12'h0F4;
    localparam logic [11:0] CH_BASE   = 12'h100;
    localparam logic [11:0] CH_STRIDE = 12'h010;

    localparam logic [3:0] OFF_CMPL   = 4'h0;
    localparam logic [3:0] OFF_CMPH   = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;
    localparam logic [3:0] OFF_PERIOD = 4'hC;

    localparam int CTRL_ARM      = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_INT_EN   = 2;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        DONE     = 2'd2
    } ch_state_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] result;
        result = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) result[8*b +: 8] = new_val[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/timer_cmp_ch.sv
// One compare channel: compare/PERIOD registers, arm FSM, match and reload.
// TIMER_CMP_SHADOW_EN stages CMPL in a shadow that a CMPH write commits.
module timer_cmp_ch
    import timer_cmp_pkg::*;
#(
    parameter int CNT_W = TIMER_CNT_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [CNT_W-1:0] cnt_val,
    input  logic             wr_cmpl,
    input  logic             wr_cmph,
    input  logic             wr_ctrl,
    input  logic             wr_period,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    output logic [CNT_W-1:0] compare,
    output logic [31:0]      period,
    output ch_state_t        state,
    output logic             periodic,
    output logic             int_en,
    output logic             hit
);

    logic disarm_wr;
`ifdef TIMER_CMP_SHADOW_EN
    logic [31:0] shadow;
`endif

    // A disarming CTRL write in the match cycle suppresses that match.
    assign disarm_wr = wr_ctrl && !wdata[CTRL_ARM];
    assign hit       = (state == ARMED) && (cnt_val == compare) && !disarm_wr;

    // NOTE: all sequential state uses non-blocking assignments so the reload
    // adder and the FSM both see the pre-edge compare value.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= DISARMED;
            periodic <= 1'b0;
            int_en   <= 1'b0;
            compare  <= '1;
            period   <= '0;
`ifdef TIMER_CMP_SHADOW_EN
            shadow   <= '1;
`endif
        end else begin
            if (hit) begin
                if (periodic) compare <= compare + CNT_W'(period);
                else          state   <= DONE;
            end

            if (wr_ctrl) begin
                state    <= wdata[CTRL_ARM] ? ARMED : DISARMED;
                periodic <= wdata[CTRL_PERIODIC];
                int_en   <= wdata[CTRL_INT_EN];
            end

            if (wr_period) period <= apply_strb(period, wdata, wstrb);

            // Compare writes are only accepted while not ARMED, so they never
            // collide with a periodic reload.
`ifdef TIMER_CMP_SHADOW_EN
            if (wr_cmpl) shadow <= apply_strb(shadow, wdata, wstrb);
            if (wr_cmph) compare <= {apply_strb(compare[CNT_W-1:32], wdata, wstrb), shadow};
`else
            if (wr_cmpl) compare[31:0]       <= apply_strb(compare[31:0], wdata, wstrb);
            if (wr_cmph) compare[CNT_W-1:32] <= apply_strb(compare[CNT_W-1:32], wdata, wstrb);
`endif
        end
    end

endmodule

// File: rtl/timer_cmp_bank.sv
// Multi-channel compare/interrupt bank: address decode, write checking, ISR/IPR
// and read mux around NUM_CH timer_cmp_ch instances (TIMER_CMP_SHADOW_EN optional).
module timer_cmp_bank
    import timer_cmp_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = TIMER_CNT_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [11:0]       tim_paddr,
    input  logic [31:0]       tim_pwdata,
    input  logic [3:0]        tim_pstrb,
    output logic [31:0]       tim_prdata,
    input  logic [CNT_W-1:0]  cnt_val,
    output logic [NUM_CH-1:0] ch_int,
    output logic              tim_int,
    output logic              reg_error_flag
);

    logic [11:0] ch_off;
    logic [2:0]  ch_idx;
    logic [3:0]  reg_off;
    logic        in_ch_span;
    logic        ch_valid;
    logic        is_isr;
    logic        is_ipr;
    logic        unmapped_wr;
    logic        wr_ok;
    logic [31:0] rd_word;

    logic [NUM_CH-1:0] status;
    logic [NUM_CH-1:0] isr_clr;
    logic [NUM_CH-1:0] hit_vec;
    logic [NUM_CH-1:0] int_en_vec;
    logic [NUM_CH-1:0] periodic_vec;
    logic [NUM_CH-1:0] err_ch;

    logic [CNT_W-1:0] cmp_arr [NUM_CH];
    logic [31:0]      per_arr [NUM_CH];
    ch_state_t        st_arr  [NUM_CH];

    assign ch_off     = tim_paddr - CH_BASE;
    assign in_ch_span = (tim_paddr >= CH_BASE) && (ch_off < 12'(MAX_CH) * CH_STRIDE);
    assign ch_idx     = ch_off[6:4];
    assign reg_off    = ch_off[3:0];
    assign ch_valid   = in_ch_span && (int'(ch_idx) < NUM_CH) && (reg_off[1:0] == 2'b00);
    assign is_isr     = (tim_paddr == ADDR_ISR);
    assign is_ipr     = (tim_paddr == ADDR_IPR);

    assign unmapped_wr    = wr_en && !(is_isr || is_ipr || ch_valid);
    assign reg_error_flag = unmapped_wr || (|err_ch);
    assign wr_ok          = wr_en && !reg_error_flag;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic sel;
        logic ctrl_wr_hit;

        assign sel         = ch_valid && (ch_idx == 3'(n));
        assign ctrl_wr_hit = sel && (reg_off == OFF_CTRL) && tim_pstrb[0];

        // Value registers are frozen while ARMED; periodic arming needs a non-zero PERIOD.
        assign err_ch[n] = wr_en && sel &&
            (((reg_off != OFF_CTRL) && (st_arr[n] == ARMED)) ||
             ((reg_off == OFF_CTRL) && tim_pstrb[0] && tim_pwdata[CTRL_ARM] &&
              tim_pwdata[CTRL_PERIODIC] && (per_arr[n] == 32'd0)));

        timer_cmp_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .cnt_val   (cnt_val),
            .wr_cmpl   (wr_ok && sel && (reg_off == OFF_CMPL)),
            .wr_cmph   (wr_ok && sel && (reg_off == OFF_CMPH)),
            .wr_ctrl   (wr_ok && ctrl_wr_hit),
            .wr_period (wr_ok && sel && (reg_off == OFF_PERIOD)),
            .wdata     (tim_pwdata),
            .wstrb     (tim_pstrb),
            .compare   (cmp_arr[n]),
            .period    (per_arr[n]),
            .state     (st_arr[n]),
            .periodic  (periodic_vec[n]),
            .int_en    (int_en_vec[n]),
            .hit       (hit_vec[n])
        );
    end

    // Set has priority over write-1-to-clear on the same edge.
    assign isr_clr = (wr_ok && is_isr && tim_pstrb[0]) ? tim_pwdata[NUM_CH-1:0] : '0;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) status <= '0;
        else            status <= (status & ~isr_clr) | hit_vec;
    end

    assign ch_int  = status & int_en_vec;
    assign tim_int = |ch_int;

    // NOTE: rd_word gets a default before any branch so no path infers a latch.
    always_comb begin
        rd_word = '0;
        if (is_isr) begin
            rd_word = 32'(status);
        end else if (is_ipr) begin
            rd_word = 32'(ch_int);
        end else if (ch_valid) begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (ch_idx == 3'(n)) begin
                    case (reg_off)
                        OFF_CMPL:   rd_word = cmp_arr[n][31:0];
                        OFF_CMPH:   rd_word = cmp_arr[n][CNT_W-1:32];
                        OFF_CTRL:   rd_word = {29'd0, int_en_vec[n], periodic_vec[n],
                                               st_arr[n] == ARMED};
                        OFF_PERIOD: rd_word = per_arr[n];
                        default:    rd_word = '0;
                    endcase
                end
            end
        end
    end

    assign tim_prdata = rd_en ? rd_word : 32'd0;

endmodule

// File: tb/tb_timer_cmp_bank.sv
// Self-checking bench for timer_cmp_bank; expected register reads and interrupt
// levels are queued as stimulus is applied and compared as the DUT responds.
module tb_timer_cmp_bank;

    localparam int NUM_CH = 4;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] val;
    } rd_exp_t;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        err;
    } wr_vec_t;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic              wr_en;
    logic              rd_en;
    logic [11:0]       tim_paddr;
    logic [31:0]       tim_pwdata;
    logic [3:0]        tim_pstrb;
    logic [31:0]       tim_prdata;
    logic [63:0]       cnt_val;
    logic [NUM_CH-1:0] ch_int;
    logic              tim_int;
    logic              reg_error_flag;

    int n_tests = 0;
    int n_fail  = 0;

    rd_exp_t rd_q  [$];
    logic    bit_q [$];

    timer_cmp_bank #(
        .NUM_CH (NUM_CH),
        .CNT_W  (64)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .wr_en          (wr_en),
        .rd_en          (rd_en),
        .tim_paddr      (tim_paddr),
        .tim_pwdata     (tim_pwdata),
        .tim_pstrb      (tim_pstrb),
        .tim_prdata     (tim_prdata),
        .cnt_val        (cnt_val),
        .ch_int         (ch_int),
        .tim_int        (tim_int),
        .reg_error_flag (reg_error_flag)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] ch_addr(input int n, input logic [3:0] off);
        return 12'h100 + 12'(n * 16) + {8'd0, off};
    endfunction

    task automatic wr_reg(input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic err);
        @(negedge sys_clk);
        wr_en = 1'b1; tim_paddr = a; tim_pwdata = d; tim_pstrb = s;
        #1 err = reg_error_flag;
        @(negedge sys_clk);
        wr_en = 1'b0;
    endtask

    task automatic rd_reg(input logic [11:0] a, output logic [31:0] d);
        rd_en = 1'b1; tim_paddr = a;
        #1 d = tim_prdata;
        rd_en = 1'b0;
    endtask

    task automatic step(input logic [63:0] v);
        @(negedge sys_clk);
        cnt_val = v;
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rd_exp_t x;
        rd_q.push_back('{12'h0F0, 32'h0});
        rd_q.push_back('{12'h0F4, 32'h0});
        rd_q.push_back('{ch_addr(0, 4'h0), 32'hFFFF_FFFF});
        rd_q.push_back('{ch_addr(1, 4'h4), 32'hFFFF_FFFF});
        rd_q.push_back('{ch_addr(2, 4'h8), 32'h0});
        rd_q.push_back('{ch_addr(3, 4'hC), 32'h0});
        while (rd_q.size() > 0) begin
            x = rd_q.pop_front();
            rd_reg(x.addr, d); n_tests++;
            if (d !== x.val) begin n_fail++; $display("FAIL reset_rd @%h: got %h want %h", x.addr, d, x.val); end
        end
        n_tests++;
        if (tim_int !== 1'b0 || ch_int !== '0) begin n_fail++; $display("FAIL reset_int: got %b/%b want 0", tim_int, ch_int); end
        rd_reg(12'h200, d); n_tests++;
        if (d !== 32'h0 || reg_error_flag !== 1'b0) begin n_fail++; $display("FAIL unmapped_rd: got %h err %b want 0", d, reg_error_flag); end
    endtask

    task automatic test_oneshot();
        logic err;
        logic exp_int;
        logic [31:0] d;
        rd_exp_t x;
        cnt_val = 64'd0;
        wr_reg(ch_addr(0, 4'h0), 32'h10, 4'hF, err);
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL oneshot_wr_err: got %b want 0", err); end
        wr_reg(ch_addr(0, 4'h4), 32'h0, 4'hF, err);
        wr_reg(ch_addr(0, 4'h8), 32'h5, 4'h1, err);
        for (int v = 0; v <= 32; v++) begin
            bit_q.push_back(v >= 16);
            step(64'(v));
            exp_int = bit_q.pop_front(); n_tests++;
            if (tim_int !== exp_int) begin n_fail++; $display("FAIL oneshot_int cnt=%0h: got %b want %b", v, tim_int, exp_int); end
        end
        rd_q.push_back('{12'h0F0, 32'h1});
        rd_q.push_back('{12'h0F4, 32'h1});
        rd_q.push_back('{ch_addr(0, 4'h8), 32'h4});
        while (rd_q.size() > 0) begin
            x = rd_q.pop_front();
            rd_reg(x.addr, d); n_tests++;
            if (d !== x.val) begin n_fail++; $display("FAIL oneshot_rd @%h: got %h want %h", x.addr, d, x.val); end
        end
        wr_reg(12'h0F0, 32'h1, 4'h1, err);
        rd_reg(12'h0F0, d); n_tests++;
        if (d !== 32'h0 || tim_int !== 1'b0) begin n_fail++; $display("FAIL isr_w1c: got %h int %b want 0", d, tim_int); end
    endtask

    task automatic test_periodic();
        logic err;
        logic exp_hit;
        logic [31:0] d;
        logic [63:0] model_cmp;
        rd_exp_t x;
        model_cmp = 64'h100;
        wr_reg(ch_addr(1, 4'h0), 32'h100, 4'hF, err);
        wr_reg(ch_addr(1, 4'h4), 32'h0, 4'hF, err);
        wr_reg(ch_addr(1, 4'hC), 32'h40, 4'hF, err);
        wr_reg(ch_addr(1, 4'h8), 32'h3, 4'h1, err);
        for (int v = 'hF8; v <= 'h190; v++) begin
            bit_q.push_back(64'(v) == model_cmp);
            step(64'(v));
            exp_hit = bit_q.pop_front();
            rd_reg(12'h0F0, d); n_tests++;
            if (d !== (exp_hit ? 32'h2 : 32'h0)) begin n_fail++; $display("FAIL periodic_isr cnt=%0h: got %h want %h", v, d, exp_hit ? 32'h2 : 32'h0); end
            if (exp_hit) begin
                model_cmp = model_cmp + 64'h40;
                wr_reg(12'h0F0, 32'h2, 4'h1, err);
            end
        end
        rd_q.push_back('{ch_addr(1, 4'h0), 32'h0000_01C0});
        rd_q.push_back('{ch_addr(1, 4'h4), 32'h0});
        rd_q.push_back('{ch_addr(1, 4'h8), 32'h3});
        while (rd_q.size() > 0) begin
            x = rd_q.pop_front();
            rd_reg(x.addr, d); n_tests++;
            if (d !== x.val) begin n_fail++; $display("FAIL periodic_rd @%h: got %h want %h", x.addr, d, x.val); end
        end
        wr_reg(ch_addr(1, 4'h8), 32'h0, 4'h1, err);
    endtask

    task automatic test_wrap();
        logic err;
        logic [31:0] d;
        rd_exp_t x;
        wr_reg(ch_addr(2, 4'h0), 32'hFFFF_FFF0, 4'hF, err);
        wr_reg(ch_addr(2, 4'h4), 32'hFFFF_FFFF, 4'hF, err);
        wr_reg(ch_addr(2, 4'hC), 32'h20, 4'hF, err);
        wr_reg(ch_addr(2, 4'h8), 32'h3, 4'h1, err);
        step(64'hFFFF_FFFF_FFFF_FFF0);
        rd_q.push_back('{12'h0F0, 32'h4});
        rd_q.push_back('{ch_addr(2, 4'h0), 32'h0000_0010});
        rd_q.push_back('{ch_addr(2, 4'h4), 32'h0});
        while (rd_q.size() > 0) begin
            x = rd_q.pop_front();
            rd_reg(x.addr, d); n_tests++;
            if (d !== x.val) begin n_fail++; $display("FAIL wrap_rd @%h: got %h want %h", x.addr, d, x.val); end
        end
        wr_reg(ch_addr(2, 4'h8), 32'h0, 4'h1, err);
        wr_reg(12'h0F0, 32'h4, 4'h1, err);
    endtask

    task automatic test_errors();
        wr_vec_t tbl [12];
        logic err;
        logic [31:0] d;
        rd_exp_t x;
        cnt_val = 64'd0;
        tbl = '{
            '{ch_addr(0, 4'h0), 32'h50,        4'hF, 1'b0},
            '{ch_addr(0, 4'h4), 32'h0,         4'hF, 1'b0},
            '{ch_addr(0, 4'h8), 32'h1,         4'h1, 1'b0},
            '{ch_addr(0, 4'h0), 32'h60,        4'hF, 1'b1},
            '{ch_addr(0, 4'h4), 32'h1,         4'hF, 1'b1},
            '{ch_addr(0, 4'hC), 32'h8,         4'hF, 1'b1},
            '{ch_addr(0, 4'h8), 32'h0,         4'h1, 1'b0},
            '{ch_addr(3, 4'h8), 32'h3,         4'h1, 1'b1},
            '{ch_addr(3, 4'hC), 32'hAABB_CCDD, 4'h5, 1'b0},
            '{12'h200,          32'h1,         4'hF, 1'b1},
            '{ch_addr(4, 4'h0), 32'h1,         4'hF, 1'b1},
            '{12'h0F0,          32'h0,         4'h1, 1'b0}
        };
        foreach (tbl[i]) begin
            wr_reg(tbl[i].addr, tbl[i].data, tbl[i].strb, err); n_tests++;
            if (err !== tbl[i].err) begin n_fail++; $display("FAIL err_flag[%0d] @%h: got %b want %b", i, tbl[i].addr, err, tbl[i].err); end
        end
        rd_q.push_back('{ch_addr(0, 4'h0), 32'h50});
        rd_q.push_back('{ch_addr(0, 4'h4), 32'h0});
        rd_q.push_back('{ch_addr(0, 4'hC), 32'h0});
        rd_q.push_back('{ch_addr(3, 4'h8), 32'h0});
        rd_q.push_back('{ch_addr(3, 4'hC), 32'h00BB_00DD});
        rd_q.push_back('{ch_addr(4, 4'h0), 32'h0});
        while (rd_q.size() > 0) begin
            x = rd_q.pop_front();
            rd_reg(x.addr, d); n_tests++;
            if (d !== x.val) begin n_fail++; $display("FAIL err_rd @%h: got %h want %h", x.addr, d, x.val); end
        end
    endtask

    task automatic test_simultaneous();
        logic err;
        logic [31:0] d;
        cnt_val = 64'd0;
        wr_reg(ch_addr(0, 4'h0), 32'h30, 4'hF, err);
        wr_reg(ch_addr(0, 4'h4), 32'h0, 4'hF, err);
        wr_reg(ch_addr(0, 4'h8), 32'h5, 4'h1, err);
        @(negedge sys_clk);
        cnt_val = 64'h30;
        wr_en = 1'b1; tim_paddr = 12'h0F0; tim_pwdata = 32'h1; tim_pstrb = 4'h1;
        @(negedge sys_clk);
        wr_en = 1'b0; cnt_val = 64'd0;
        rd_reg(12'h0F0, d); n_tests++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL set_wins_isr: got %h want 1", d); end
        wr_reg(12'h0F0, 32'h1, 4'h1, err);
        wr_reg(ch_addr(0, 4'h0), 32'h40, 4'hF, err);
        wr_reg(ch_addr(0, 4'h8), 32'h5, 4'h1, err);
        @(negedge sys_clk);
        cnt_val = 64'h40;
        wr_en = 1'b1; tim_paddr = ch_addr(0, 4'h8); tim_pwdata = 32'h4; tim_pstrb = 4'h1;
        @(negedge sys_clk);
        wr_en = 1'b0;
        rd_reg(12'h0F0, d); n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL disarm_wins_isr: got %h want 0", d); end
        step(64'h40);
        rd_reg(ch_addr(0, 4'h8), d); n_tests++;
        if (d !== 32'h4 || tim_int !== 1'b0) begin n_fail++; $display("FAIL disarm_ctrl: got %h int %b want 4/0", d, tim_int); end
    endtask

    task automatic test_reset_midop();
        logic err;
        logic [31:0] d;
        rd_exp_t x;
        cnt_val = 64'd0;
        wr_reg(ch_addr(0, 4'h0), 32'h60, 4'hF, err);
        wr_reg(ch_addr(0, 4'hC), 32'h10, 4'hF, err);
        wr_reg(ch_addr(0, 4'h8), 32'h7, 4'h1, err);
        step(64'h60);
        n_tests++;
        if (tim_int !== 1'b1) begin n_fail++; $display("FAIL midop_pre_int: got %b want 1", tim_int); end
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        n_tests++;
        if (tim_int !== 1'b0 || ch_int !== '0) begin n_fail++; $display("FAIL midop_int: got %b/%b want 0", tim_int, ch_int); end
        rd_q.push_back('{12'h0F0, 32'h0});
        rd_q.push_back('{ch_addr(0, 4'h0), 32'hFFFF_FFFF});
        rd_q.push_back('{ch_addr(0, 4'h4), 32'hFFFF_FFFF});
        rd_q.push_back('{ch_addr(0, 4'h8), 32'h0});
        rd_q.push_back('{ch_addr(0, 4'hC), 32'h0});
        while (rd_q.size() > 0) begin
            x = rd_q.pop_front();
            rd_reg(x.addr, d); n_tests++;
            if (d !== x.val) begin n_fail++; $display("FAIL midop_rd @%h: got %h want %h", x.addr, d, x.val); end
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step(64'hFFFF_FFFF_FFFF_FFFF);
        rd_reg(12'h0F0, d); n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL midop_disarmed: got %h want 0", d); end
    endtask

    task automatic test_shadow();
        logic err;
        logic [31:0] d;
        logic [31:0] exp_cmpl;
        logic [31:0] exp_isr;
`ifdef TIMER_CMP_SHADOW_EN
        exp_cmpl = 32'hFFFF_FFFF;
        exp_isr  = 32'h0;
`else
        exp_cmpl = 32'h5;
        exp_isr  = 32'h1;
`endif
        cnt_val = 64'd0;
        wr_reg(ch_addr(0, 4'h4), 32'h0, 4'hF, err);
        wr_reg(ch_addr(0, 4'h0), 32'h5, 4'hF, err);
        rd_reg(ch_addr(0, 4'h0), d); n_tests++;
        if (d !== exp_cmpl) begin n_fail++; $display("FAIL shadow_cmpl: got %h want %h", d, exp_cmpl); end
        wr_reg(ch_addr(0, 4'h8), 32'h5, 4'h1, err);
        step(64'h4);
        step(64'h5);
        rd_reg(12'h0F0, d); n_tests++;
        if (d !== exp_isr) begin n_fail++; $display("FAIL shadow_pre_commit: got %h want %h", d, exp_isr); end
        wr_reg(12'h0F0, 32'h1, 4'h1, err);
        wr_reg(ch_addr(0, 4'h8), 32'h0, 4'h1, err);
        wr_reg(ch_addr(0, 4'h4), 32'h0, 4'hF, err);
        wr_reg(ch_addr(0, 4'h8), 32'h5, 4'h1, err);
        step(64'h4);
        step(64'h5);
        rd_reg(12'h0F0, d); n_tests++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL shadow_post_commit: got %h want 1", d); end
        rd_reg(ch_addr(0, 4'h0), d); n_tests++;
        if (d !== 32'h5) begin n_fail++; $display("FAIL shadow_committed: got %h want 5", d); end
    endtask

    initial begin
        sys_rst_n  = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        tim_paddr  = '0;
        tim_pwdata = '0;
        tim_pstrb  = '0;
        cnt_val    = '0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        test_reset();
        test_oneshot();
        test_periodic();
        test_wrap();
        test_errors();
        test_simultaneous();
        test_reset_midop();
        test_shadow();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
